// File: rtl/fft_pkg.sv
// Shared widths, complex sample / twiddle types and the W64 twiddle ROM
// for the inter-stage FFT twiddle multiplier.
package fft_pkg;

    localparam int N        = 16;
    localparam int IN_BIT   = 10;
    localparam int OUT_BIT  = 10;
    localparam int TW_BIT   = 9;
    localparam int NUM_BLK  = 4;
    localparam int FRAC     = 7;
    localparam int PROD_BIT = IN_BIT + TW_BIT;
    localparam int SUM_BIT  = PROD_BIT + 1;
    localparam int RND_BIT  = SUM_BIT - FRAC;
    localparam int BLK_BIT  = $clog2(NUM_BLK);
    localparam int M_BIT    = 6;

    typedef struct packed {
        logic signed [IN_BIT-1:0] re;
        logic signed [IN_BIT-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_BIT-1:0] c;
        logic signed [TW_BIT-1:0] d;
    } tw_t;

    function automatic tw_t tw(input int c, input int d);
        return '{c: TW_BIT'(c), d: TW_BIT'(d)};
    endfunction

    // Entry m = (round(128*cos(2*pi*m/64)), -round(128*sin(2*pi*m/64)))
    localparam tw_t TW_ROM [64] = '{
        tw( 128,    0), tw( 127,  -13), tw( 126,  -25), tw( 122,  -37),
        tw( 118,  -49), tw( 113,  -60), tw( 106,  -71), tw(  99,  -81),
        tw(  91,  -91), tw(  81,  -99), tw(  71, -106), tw(  60, -113),
        tw(  49, -118), tw(  37, -122), tw(  25, -126), tw(  13, -127),
        tw(   0, -128), tw( -13, -127), tw( -25, -126), tw( -37, -122),
        tw( -49, -118), tw( -60, -113), tw( -71, -106), tw( -81,  -99),
        tw( -91,  -91), tw( -99,  -81), tw(-106,  -71), tw(-113,  -60),
        tw(-118,  -49), tw(-122,  -37), tw(-126,  -25), tw(-127,  -13),
        tw(-128,    0), tw(-127,   13), tw(-126,   25), tw(-122,   37),
        tw(-118,   49), tw(-113,   60), tw(-106,   71), tw( -99,   81),
        tw( -91,   91), tw( -81,   99), tw( -71,  106), tw( -60,  113),
        tw( -49,  118), tw( -37,  122), tw( -25,  126), tw( -13,  127),
        tw(   0,  128), tw(  13,  127), tw(  25,  126), tw(  37,  122),
        tw(  49,  118), tw(  60,  113), tw(  71,  106), tw(  81,   99),
        tw(  91,   91), tw(  99,   81), tw( 106,   71), tw( 113,   60),
        tw( 118,   49), tw( 122,   37), tw( 126,   25), tw( 127,   13)
    };

    function automatic logic [M_BIT-1:0] tw_index(input int unsigned lane,
                                                  input logic [BLK_BIT-1:0] blk);
        return M_BIT'(lane * 32'(blk));
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// One lane of the twiddle multiplier: registered products, then round/narrow.
// Saturating narrowing is selected with the TW_SAT_EN macro.
module fft_cmul
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en1_i,
    input  logic                      en2_i,
    input  cplx_t                     x_i,
    input  tw_t                       w_i,
    output logic signed [OUT_BIT-1:0] re_o,
    output logic signed [OUT_BIT-1:0] im_o,
    output logic                      sat_o
);

    localparam logic signed [SUM_BIT-1:0] HALF = SUM_BIT'(1 << (FRAC - 1));

    logic signed [IN_BIT-1:0]   a, b;
    logic signed [TW_BIT-1:0]   c, d;
    logic signed [PROD_BIT-1:0] ac_q, bd_q, ad_q, bc_q;
    logic signed [SUM_BIT-1:0]  sum_re, sum_im;
    logic signed [OUT_BIT-1:0]  re_d, im_d, re_q, im_q;

    assign a = x_i.re;
    assign b = x_i.im;
    assign c = w_i.c;
    assign d = w_i.d;

    always_ff @(posedge clk) begin
        if (en1_i) begin
            ac_q <= PROD_BIT'(a) * PROD_BIT'(c);
            bd_q <= PROD_BIT'(b) * PROD_BIT'(d);
            ad_q <= PROD_BIT'(a) * PROD_BIT'(d);
            bc_q <= PROD_BIT'(b) * PROD_BIT'(c);
        end
    end

    assign sum_re = SUM_BIT'(ac_q) - SUM_BIT'(bd_q);
    assign sum_im = SUM_BIT'(ad_q) + SUM_BIT'(bc_q);

`ifdef TW_SAT_EN
    localparam logic signed [RND_BIT-1:0] OUT_MAX = RND_BIT'((1 << (OUT_BIT - 1)) - 1);
    localparam logic signed [RND_BIT-1:0] OUT_MIN = RND_BIT'(-(1 << (OUT_BIT - 1)));

    logic signed [RND_BIT-1:0] rnd_re, rnd_im;
    logic                      sat_re, sat_im, sat_q;

    // Round half up toward +inf, then clip into the output range.
    always_comb begin
        rnd_re = RND_BIT'((sum_re + HALF) >>> FRAC);
        rnd_im = RND_BIT'((sum_im + HALF) >>> FRAC);
        re_d   = rnd_re[OUT_BIT-1:0];
        im_d   = rnd_im[OUT_BIT-1:0];
        sat_re = 1'b0;
        sat_im = 1'b0;
        if (rnd_re > OUT_MAX) begin
            re_d = OUT_MAX[OUT_BIT-1:0]; sat_re = 1'b1;
        end else if (rnd_re < OUT_MIN) begin
            re_d = OUT_MIN[OUT_BIT-1:0]; sat_re = 1'b1;
        end
        if (rnd_im > OUT_MAX) begin
            im_d = OUT_MAX[OUT_BIT-1:0]; sat_im = 1'b1;
        end else if (rnd_im < OUT_MIN) begin
            im_d = OUT_MIN[OUT_BIT-1:0]; sat_im = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_q <= 1'b0;
        else if (en2_i)
            sat_q <= sat_re | sat_im;
    end

    assign sat_o = sat_q;
`else
    always_comb begin
        re_d = OUT_BIT'((sum_re + HALF) >>> FRAC);
        im_d = OUT_BIT'((sum_im + HALF) >>> FRAC);
    end

    assign sat_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en2_i) begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: rtl/fft_twiddle_mul.sv
// 16-lane inter-stage twiddle multiplier, 3-cycle latency, valid-only handshake.
// Define TW_SAT_EN for saturating narrowing and a live sat_o.
module fft_twiddle_mul
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic                      sof_i,
    input  logic signed [IN_BIT-1:0]  din_i  [0:N-1],
    input  logic signed [IN_BIT-1:0]  din_q  [0:N-1],
    output logic                      valid_o,
    output logic                      sof_o,
    output logic signed [OUT_BIT-1:0] dout_i [0:N-1],
    output logic signed [OUT_BIT-1:0] dout_q [0:N-1],
    output logic                      sat_o
);

    logic [BLK_BIT-1:0] blk_q, blk_d, blk_used;
    logic               v1_q, v2_q, v3_q;
    logic               sof1_q, sof2_q, sof3_q;
    cplx_t              x1_q [N];
    tw_t                w1_q [N];
    logic [N-1:0]       lane_sat;

    // A sof beat always uses block 0, even when it coincides with the wrap.
    always_comb begin
        blk_used = sof_i ? '0 : blk_q;
        blk_d    = blk_q;
        if (valid_i)
            blk_d = (blk_used == BLK_BIT'(NUM_BLK - 1)) ? '0 : blk_used + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sof1_q <= 1'b0;
            sof2_q <= 1'b0;
            sof3_q <= 1'b0;
        end else begin
            blk_q  <= blk_d;
            v1_q   <= valid_i;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            sof1_q <= valid_i & sof_i;
            sof2_q <= sof1_q;
            sof3_q <= sof2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) begin
            for (int unsigned l = 0; l < N; l++) begin
                x1_q[l] <= '{re: din_i[l], im: din_q[l]};
                w1_q[l] <= TW_ROM[tw_index(l, blk_used)];
            end
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        fft_cmul u_cmul (
            .clk   (clk),
            .rst   (rst),
            .en1_i (v1_q),
            .en2_i (v2_q),
            .x_i   (x1_q[l]),
            .w_i   (w1_q[l]),
            .re_o  (dout_i[l]),
            .im_o  (dout_q[l]),
            .sat_o (lane_sat[l])
        );
    end

    assign valid_o = v3_q;
    assign sof_o   = sof3_q;
    assign sat_o   = |lane_sat;

endmodule
